// File: rtl/tristate_bus_ctrl.sv
// tristate_bus_ctrl: single-master tristate bus write/sample controller
// with programmable turnaround cycles around every driven cycle.
module tristate_bus_ctrl #(
  parameter int WIDTH    = 8,
  parameter int TURN_CYC = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_valid,
  input  logic [WIDTH-1:0] wr_data,
  output logic             wr_ready,
  input  logic             rd_req,
  output logic             rd_valid,
  output logic [WIDTH-1:0] rd_data,
  inout  wire  [WIDTH-1:0] bus_io,
  output logic             bus_oe,
  output logic             busy
);

  typedef enum logic [2:0] {
    IDLE,
    TURN_TX,
    DRIVE,
    TURN_RX,
    SAMPLE
  } state_t;

  localparam logic [3:0] TURN_LD =
    (TURN_CYC > 0) ? 4'(TURN_CYC - 1) : 4'd0;

  state_t           state_q;
  state_t           state_d;
  logic [3:0]       cnt_q;
  logic [3:0]       cnt_d;
  logic [WIDTH-1:0] out_q;
  logic             capture;

  assign busy     = (state_q != IDLE);
  assign wr_ready = rst_n && (state_q == IDLE);
  assign bus_io   = bus_oe ? out_q : {WIDTH{1'bz}};

  // State and turnaround counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state, counter load/decrement and write capture strobe
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    capture = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (wr_valid) begin
          capture = 1'b1;
          if (TURN_CYC > 0) begin
            state_d = TURN_TX;
            cnt_d   = TURN_LD;
          end else begin
            state_d = DRIVE;
          end
        end else if (rd_req) begin
          state_d = SAMPLE;
        end
      end
      TURN_TX: begin
        if (cnt_q == 4'd0) state_d = DRIVE;
        else cnt_d = cnt_q - 4'd1;
      end
      DRIVE: begin
        if (TURN_CYC > 0) begin
          state_d = TURN_RX;
          cnt_d   = TURN_LD;
        end else begin
          state_d = IDLE;
        end
      end
      TURN_RX: begin
        if (cnt_q == 4'd0) state_d = IDLE;
        else cnt_d = cnt_q - 4'd1;
      end
      SAMPLE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // Output enable follows the state register, high only in DRIVE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) bus_oe <= 1'b0;
    else bus_oe <= (state_d == DRIVE);
  end

  // Output data register, loaded only on an accepted write
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) out_q <= '0;
    else if (capture) out_q <= wr_data;
  end

  // Bus sample at the end of SAMPLE plus one-cycle valid pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      rd_valid <= (state_q == SAMPLE);
      if (state_q == SAMPLE) rd_data <= bus_io;
    end
  end

endmodule

// File: tb/tb_tristate_bus_ctrl.sv
// tb_tristate_bus_ctrl: two instances (turnaround 1 and 0) on separate
// buses, each with an external driver active only while bus_oe is low.
module tb_tristate_bus_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       wr_valid = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       rd_req = 1'b0;
  logic [7:0] ext_val = 8'h3C;

  logic [1:0] wr_ready;
  logic [1:0] rd_valid;
  logic [1:0] bus_oe;
  logic [1:0] busy;
  logic [7:0] rd_data [2];
  wire  [7:0] bus0;
  wire  [7:0] bus1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign bus0 = bus_oe[0] ? {8{1'bz}} : ext_val;
  assign bus1 = bus_oe[1] ? {8{1'bz}} : ext_val;

  tristate_bus_ctrl #(.WIDTH(8), .TURN_CYC(1)) u_a (
    .clk(clk), .rst_n(rst_n),
    .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready[0]),
    .rd_req(rd_req), .rd_valid(rd_valid[0]), .rd_data(rd_data[0]),
    .bus_io(bus0), .bus_oe(bus_oe[0]), .busy(busy[0])
  );

  tristate_bus_ctrl #(.WIDTH(8), .TURN_CYC(0)) u_b (
    .clk(clk), .rst_n(rst_n),
    .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready[1]),
    .rd_req(rd_req), .rd_valid(rd_valid[1]), .rd_data(rd_data[1]),
    .bus_io(bus1), .bus_oe(bus_oe[1]), .busy(busy[1])
  );

  // Timeline model: each transaction is a set of edge numbers.
  int         tc [2] = '{1, 0};
  int         cyc = 0;
  int         free_at [2];
  int         drv_edge [2];
  int         samp_edge [2];
  logic [7:0] drv_data [2];
  logic [7:0] m_rd [2];

  typedef struct {
    logic       wv;
    logic [7:0] wd;
    logic       rq;
    logic [7:0] ext;
    logic       oe;
    logic       rdy;
    logic       rdv;
    logic [7:0] rdat;
    logic [7:0] bus;
  } vec_t;

  vec_t tbl [14];

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] bus_of(input int d);
    return (d == 0) ? bus0 : bus1;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      free_at[d]   = 0;
      drv_edge[d]  = -100;
      samp_edge[d] = -100;
      drv_data[d]  = 8'h00;
      m_rd[d]      = 8'h00;
    end
  endtask

  task automatic model_edge();
    cyc++;
    for (int d = 0; d < 2; d++) begin
      if (cyc == samp_edge[d] + 1) m_rd[d] = ext_val;
      if (free_at[d] <= cyc) begin
        if (wr_valid) begin
          drv_edge[d] = cyc;
          drv_data[d] = wr_data;
          free_at[d]  = cyc + 2 * tc[d] + 2;
        end else if (rd_req) begin
          samp_edge[d] = cyc;
          free_at[d]   = cyc + 2;
        end
      end
    end
  endtask

  task automatic check_model();
    logic       e_oe;
    logic       e_rdy;
    logic       e_rdv;
    logic [7:0] e_bus;
    for (int d = 0; d < 2; d++) begin
      e_oe  = (cyc == drv_edge[d] + tc[d]);
      e_rdy = (free_at[d] <= cyc + 1);
      e_rdv = (cyc == samp_edge[d] + 1);
      e_bus = e_oe ? drv_data[d] : ext_val;
      chk($sformatf("m%0d_oe", d), bus_oe[d], e_oe);
      chk($sformatf("m%0d_rdy", d), wr_ready[d], e_rdy);
      chk($sformatf("m%0d_busy", d), busy[d], !e_rdy);
      chk($sformatf("m%0d_rdv", d), rd_valid[d], e_rdv);
      chk($sformatf("m%0d_rdat", d), rd_data[d], m_rd[d]);
      chk($sformatf("m%0d_bus", d), bus_of(d), e_bus);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_model();
  endtask

  initial begin
    tbl[0]  = '{1'b1, 8'hA5, 1'b0, 8'h3C, 1'b0, 1'b0, 1'b0, 8'h00, 8'h3C};
    tbl[1]  = '{1'b0, 8'h5A, 1'b0, 8'h3C, 1'b1, 1'b0, 1'b0, 8'h00, 8'hA5};
    tbl[2]  = '{1'b1, 8'h77, 1'b0, 8'h3C, 1'b0, 1'b0, 1'b0, 8'h00, 8'h3C};
    tbl[3]  = '{1'b0, 8'h00, 1'b0, 8'h3C, 1'b0, 1'b1, 1'b0, 8'h00, 8'h3C};
    tbl[4]  = '{1'b0, 8'h00, 1'b1, 8'h3C, 1'b0, 1'b0, 1'b0, 8'h00, 8'h3C};
    tbl[5]  = '{1'b0, 8'h00, 1'b0, 8'h3C, 1'b0, 1'b1, 1'b1, 8'h3C, 8'h3C};
    tbl[6]  = '{1'b0, 8'h00, 1'b0, 8'h3C, 1'b0, 1'b1, 1'b0, 8'h3C, 8'h3C};
    tbl[7]  = '{1'b1, 8'hC3, 1'b1, 8'h3C, 1'b0, 1'b0, 1'b0, 8'h3C, 8'h3C};
    tbl[8]  = '{1'b0, 8'h00, 1'b1, 8'h3C, 1'b1, 1'b0, 1'b0, 8'h3C, 8'hC3};
    tbl[9]  = '{1'b0, 8'h00, 1'b1, 8'h3C, 1'b0, 1'b0, 1'b0, 8'h3C, 8'h3C};
    tbl[10] = '{1'b0, 8'h00, 1'b1, 8'h3C, 1'b0, 1'b1, 1'b0, 8'h3C, 8'h3C};
    tbl[11] = '{1'b0, 8'h00, 1'b1, 8'h3C, 1'b0, 1'b0, 1'b0, 8'h3C, 8'h3C};
    tbl[12] = '{1'b0, 8'h00, 1'b0, 8'h96, 1'b0, 1'b1, 1'b1, 8'h96, 8'h96};
    tbl[13] = '{1'b0, 8'h00, 1'b0, 8'h96, 1'b0, 1'b1, 1'b0, 8'h96, 8'h96};

    model_reset();

    // Held in reset
    repeat (2) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("rst%0d_rdy", d), wr_ready[d], 1'b0);
      chk($sformatf("rst%0d_busy", d), busy[d], 1'b0);
      chk($sformatf("rst%0d_oe", d), bus_oe[d], 1'b0);
      chk($sformatf("rst%0d_rdv", d), rd_valid[d], 1'b0);
      chk($sformatf("rst%0d_rdat", d), rd_data[d], 8'h00);
      chk($sformatf("rst%0d_bus", d), bus_of(d), ext_val);
    end

    // Release and idle five cycles
    rst_n = 1'b1;
    #1;
    chk("rel_rdy", wr_ready[0], 1'b1);
    @(negedge clk);
    repeat (5) step();
    chk("idle5_rdy", wr_ready[0], 1'b1);
    chk("idle5_oe", bus_oe[0], 1'b0);
    chk("idle5_rdv", rd_valid[0], 1'b0);
    chk("idle5_rdat", rd_data[0], 8'h00);
    chk("idle5_bus", bus0, 8'h3C);

    // Directed table on the turnaround-1 instance
    for (int i = 0; i < 14; i++) begin
      wr_valid = tbl[i].wv;
      wr_data  = tbl[i].wd;
      rd_req   = tbl[i].rq;
      ext_val  = tbl[i].ext;
      step();
      chk($sformatf("t%0d_oe", i), bus_oe[0], tbl[i].oe);
      chk($sformatf("t%0d_rdy", i), wr_ready[0], tbl[i].rdy);
      chk($sformatf("t%0d_rdv", i), rd_valid[0], tbl[i].rdv);
      chk($sformatf("t%0d_rdat", i), rd_data[0], tbl[i].rdat);
      chk($sformatf("t%0d_bus", i), bus0, tbl[i].bus);
    end

    // Reset in the middle of DRIVE of 8'hFF
    ext_val  = 8'h3C;
    wr_valid = 1'b1;
    wr_data  = 8'hFF;
    step();
    wr_valid = 1'b0;
    wr_data  = 8'h00;
    @(posedge clk);
    model_edge();
    #2;
    chk("mid_drv_oe", bus_oe[0], 1'b1);
    chk("mid_drv_bus", bus0, 8'hFF);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_oe", bus_oe[0], 1'b0);
    chk("mid_rst_bus", bus0, 8'h3C);
    chk("mid_rst_rdy", wr_ready[0], 1'b0);
    chk("mid_rst_busy", busy[0], 1'b0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("post_rst_rdy", wr_ready[0], 1'b1);
    @(negedge clk);
    repeat (4) step();

    // Back-to-back writes on the zero-turnaround instance
    wr_valid = 1'b1;
    wr_data  = 8'h01;
    step();
    chk("b2b_d1_oe", bus_oe[1], 1'b1);
    chk("b2b_d1_bus", bus1, 8'h01);
    wr_data = 8'h02;
    step();
    chk("b2b_gap_oe", bus_oe[1], 1'b0);
    chk("b2b_gap_rdy", wr_ready[1], 1'b1);
    step();
    chk("b2b_d2_oe", bus_oe[1], 1'b1);
    chk("b2b_d2_bus", bus1, 8'h02);
    wr_valid = 1'b0;
    step();
    chk("b2b_end_oe", bus_oe[1], 1'b0);
    repeat (6) step();

    // Random traffic against the timeline model
    for (int i = 0; i < 400; i++) begin
      wr_valid = ($urandom_range(3) == 0);
      wr_data  = 8'($urandom);
      rd_req   = ($urandom_range(2) == 0);
      ext_val  = 8'($urandom);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tristate_bus_ctrl.md
TRISTATE_BUS_CTRL -- requirements
Module: tristate_bus_ctrl

Interface
REQ-001 Parameter WIDTH, default 8: bus and data width in bits; legal range 1..64.
REQ-002 Parameter TURN_CYC, default 1: bus-turnaround idle cycles; legal range 0..15.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 wr_valid  input  1  write request; paired with wr_data.
REQ-006 wr_data  input  WIDTH  value to drive onto the bus.
REQ-007 wr_ready  output  1  write accepted when wr_valid && wr_ready at a rising edge.
REQ-008 rd_req  input  1  request one sample of the bus.
REQ-009 rd_valid  output  1  single-cycle pulse; rd_data holds a new sample.
REQ-010 rd_data  output  WIDTH  last sampled bus value.
REQ-011 bus_io  inout  WIDTH  shared tristate bus; driven only while bus_oe=1, all bits 'z otherwise.
REQ-012 bus_oe  output  1  registered output enable, exported for observation.
REQ-013 busy  output  1  high in every state except IDLE.

Function
REQ-014 FSM states: IDLE, TURN_TX, DRIVE, TURN_RX, SAMPLE; state and bus_oe are registered.
REQ-015 IDLE: bus released; wr_ready=1; wr_ready=0 in all other states (combinational decode of state).
REQ-016 IDLE with wr_valid=1: capture wr_data into the output register; next state TURN_TX if TURN_CYC>0, else DRIVE.
REQ-017 IDLE with rd_req=1 and wr_valid=0: next state SAMPLE.
REQ-018 Simultaneous wr_valid and rd_req in IDLE: write wins; rd_req is not queued and must be held or re-asserted.
REQ-019 TURN_TX: bus released for exactly TURN_CYC cycles (4-bit down-counter), then DRIVE.
REQ-020 DRIVE: exactly one cycle; bus_oe=1; bus_io equals the captured wr_data.
REQ-021 After DRIVE: TURN_RX for exactly TURN_CYC cycles with the bus released, then IDLE; with TURN_CYC=0, DRIVE goes directly to IDLE.
REQ-022 Write latency: if accepted at edge t, DRIVE occupies cycle t+TURN_CYC+1; the next accept is possible at edge t+2*TURN_CYC+2.
REQ-023 SAMPLE: one cycle with the bus released; bus_io is registered into rd_data at the end of SAMPLE.
REQ-024 rd_valid is high for exactly the one cycle after SAMPLE; the FSM is in IDLE in that same cycle.
REQ-025 rd_data holds its value until the next SAMPLE; z/x bits are passed through unmodified (no resolution).
REQ-026 wr_data changes while not in IDLE have no effect on the driven value.
REQ-027 The counter never wraps: it is loaded with TURN_CYC-1 on entry to a TURN state and stops at 0.
REQ-028 bus_oe=1 only in DRIVE; no two consecutive DRIVE cycles are possible when TURN_CYC>0.

Reset
REQ-029 rst_n=0 forces immediately, without a clock: state=IDLE, bus_oe=0, bus_io all 'z, rd_valid=0, rd_data=0, counter=0, output register=0.
REQ-030 While rst_n=0, wr_ready=0 and busy=0; after rst_n deasserts, wr_ready=1 from the first cycle.
REQ-031 Reset asserted during DRIVE releases the bus in the same timestep; the in-flight write is dropped with no replay.

Verification
REQ-032 Reset, then idle 5 cycles -> bus_io=8'hzz, bus_oe=0, wr_ready=1, rd_valid=0, rd_data=8'h00.
REQ-033 TURN_CYC=1, wr_data=8'hA5 accepted at edge t -> bus_oe=1 and bus_io=8'hA5 only in cycle t+2; wr_ready=1 again in cycle t+4.
REQ-034 External driver holds 8'h3C; rd_req pulsed one cycle -> rd_valid pulses 2 cycles later with rd_data=8'h3C, which is held afterwards.
REQ-035 wr_valid and rd_req asserted together -> write executes and no rd_valid occurs; rd_req held high -> sample taken right after TURN_RX.
REQ-036 rst_n dropped mid-cycle during DRIVE of 8'hFF -> bus_io=8'hzz with no clock edge; after release, IDLE with wr_ready=1.
REQ-037 TURN_CYC=0, back-to-back writes 8'h01, 8'h02 -> DRIVE cycles separated by exactly one IDLE cycle; no bus contention with a second driver enabled only when bus_oe=0.
